// File: rtl/bpred_btb.sv
// Direct-mapped BTB with 2-bit saturating counters: Fetch-stage lookup, Execute-stage training.
// Define BPRED_GSHARE_EN to index the counters with PC index XOR global history (gshare).
module bpred_btb #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 64,
    parameter int TAG_W   = 8,
    parameter int CNT_W   = 16,
    parameter int GHR_W   = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  pcF,
    output logic             pred_hitF,
    output logic             pred_takenF,
    output logic [XLEN-1:0]  pred_targetF,
    input  logic             upd_validE,
    input  logic [XLEN-1:0]  upd_pcE,
    input  logic [XLEN-1:0]  upd_pc_plus_4E,
    input  logic             upd_branchE,
    input  logic             upd_jumpE,
    input  logic             upd_takenE,
    input  logic [XLEN-1:0]  upd_targetE,
    input  logic             pred_takenE,
    input  logic [XLEN-1:0]  pred_targetE,
    output logic             mispredictE,
    output logic [XLEN-1:0]  redirect_pcE,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);
    localparam int IDX_W = $clog2(ENTRIES);

    logic             validQ  [ENTRIES];
    logic [TAG_W-1:0] tagQ    [ENTRIES];
    logic             isJumpQ [ENTRIES];
    logic [XLEN-1:0]  targetQ [ENTRIES];
    logic [1:0]       ctrQ    [ENTRIES];
    logic [CNT_W-1:0] branchCntQ;
    logic [CNT_W-1:0] mispredCntQ;

    // Zero-padding above the PC lets a tag reach past XLEN without range errors.
    logic [XLEN+TAG_W-1:0] pcFPad;
    logic [XLEN+TAG_W-1:0] pcEPad;
    logic [IDX_W-1:0]      idxF;
    logic [IDX_W-1:0]      idxE;
    logic [IDX_W-1:0]      ctrIdxF;
    logic [IDX_W-1:0]      ctrIdxE;
    logic [TAG_W-1:0]      tagF;
    logic [TAG_W-1:0]      tagE;

    assign pcFPad = {{TAG_W{1'b0}}, pcF};
    assign pcEPad = {{TAG_W{1'b0}}, upd_pcE};
    assign idxF   = pcF[IDX_W+1:2];
    assign idxE   = upd_pcE[IDX_W+1:2];
    assign tagF   = pcFPad[IDX_W+2 +: TAG_W];
    assign tagE   = pcEPad[IDX_W+2 +: TAG_W];

    logic unusedOk;
    assign unusedOk = ^{pcFPad, pcEPad};

`ifdef BPRED_GSHARE_EN
    logic [GHR_W-1:0] ghrQ;
    logic [GHR_W:0]   ghrShift;

    assign ghrShift = {ghrQ, upd_takenE};
    assign ctrIdxF  = idxF ^ IDX_W'(ghrQ);
    assign ctrIdxE  = idxE ^ IDX_W'(ghrQ);

    // History advances on conditional branches only; jumps carry no direction information.
    always_ff @(posedge clk) begin
        if (rst) begin
            ghrQ <= '0;
        end else if (upd_validE && upd_branchE) begin
            ghrQ <= ghrShift[GHR_W-1:0];
        end
    end
`else
    assign ctrIdxF = idxF;
    assign ctrIdxE = idxE;
`endif

    // Fetch lookup reads the registered tables only, so a same-cycle update is not visible.
    always_comb begin
        pred_hitF    = validQ[idxF] && (tagQ[idxF] == tagF);
        pred_takenF  = pred_hitF && (isJumpQ[idxF] || ctrQ[ctrIdxF][1]);
        pred_targetF = pred_hitF ? targetQ[idxF] : '0;
    end

    logic       res;
    logic       hitE;
    logic [1:0] ctrE;
    logic [1:0] ctrTrained;

    always_comb begin
        res          = upd_validE && (upd_branchE || upd_jumpE);
        hitE         = validQ[idxE] && (tagQ[idxE] == tagE);
        ctrE         = ctrQ[ctrIdxE];
        mispredictE  = res && ((upd_takenE != pred_takenE) ||
                               (upd_takenE && (upd_targetE != pred_targetE)));
        redirect_pcE = (res && upd_takenE) ? upd_targetE : upd_pc_plus_4E;
        ctrTrained   = ctrE;
        if (upd_takenE && ctrE != 2'b11) begin
            ctrTrained = ctrE + 2'b01;
        end else if (!upd_takenE && ctrE != 2'b00) begin
            ctrTrained = ctrE - 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                validQ[i]  <= 1'b0;
                tagQ[i]    <= '0;
                isJumpQ[i] <= 1'b0;
                targetQ[i] <= '0;
                ctrQ[i]    <= 2'b01;
            end
            branchCntQ  <= '0;
            mispredCntQ <= '0;
        end else if (res) begin
            if (hitE && upd_jumpE) begin
                targetQ[idxE]  <= upd_targetE;
                isJumpQ[idxE]  <= 1'b1;
                ctrQ[ctrIdxE]  <= 2'b11;
            end else if (hitE) begin
                ctrQ[ctrIdxE] <= ctrTrained;
                if (upd_takenE) begin
                    targetQ[idxE] <= upd_targetE;
                end
            end else if (upd_takenE) begin
                // Miss on a taken branch/jump: overwrite whatever lives at this index.
                validQ[idxE]  <= 1'b1;
                tagQ[idxE]    <= tagE;
                targetQ[idxE] <= upd_targetE;
                isJumpQ[idxE] <= upd_jumpE;
                ctrQ[ctrIdxE] <= upd_jumpE ? 2'b11 : 2'b10;
            end
            if (branchCntQ != '1) begin
                branchCntQ <= branchCntQ + 1'b1;
            end
            if (mispredictE && mispredCntQ != '1) begin
                mispredCntQ <= mispredCntQ + 1'b1;
            end
        end
    end

    assign branch_cnt  = branchCntQ;
    assign mispred_cnt = mispredCntQ;
endmodule

// File: tb/tb_bpred_btb.sv
// Directed plus randomized bench for bpred_btb against a table-level reference model.
// A second instance with 2-bit statistics counters checks counter saturation.
module tb_bpred_btb;
    localparam int XLEN    = 32;
    localparam int ENTRIES = 64;
    localparam int TAG_W   = 8;
    localparam int IDX_W   = 6;
    localparam int GHR_W   = 6;

    logic            clk;
    logic            rst;
    logic [31:0]     pcF;
    logic            upd_validE, upd_branchE, upd_jumpE, upd_takenE, pred_takenE;
    logic [31:0]     upd_pcE, upd_pc_plus_4E, upd_targetE, pred_targetE;

    logic            pred_hitF, pred_takenF, mispredictE;
    logic [31:0]     pred_targetF, redirect_pcE;
    logic [15:0]     branch_cnt, mispred_cnt;

    logic            smallHitF, smallTakenF, smallMispredE;
    logic [31:0]     smallTargetF, smallRedirectE;
    logic [1:0]      smallBranchCnt, smallMispredCnt;

    bpred_btb #(.XLEN(XLEN), .ENTRIES(ENTRIES), .TAG_W(TAG_W), .CNT_W(16), .GHR_W(GHR_W)) dut (
        .clk(clk), .rst(rst), .pcF(pcF),
        .pred_hitF(pred_hitF), .pred_takenF(pred_takenF), .pred_targetF(pred_targetF),
        .upd_validE(upd_validE), .upd_pcE(upd_pcE), .upd_pc_plus_4E(upd_pc_plus_4E),
        .upd_branchE(upd_branchE), .upd_jumpE(upd_jumpE), .upd_takenE(upd_takenE),
        .upd_targetE(upd_targetE), .pred_takenE(pred_takenE), .pred_targetE(pred_targetE),
        .mispredictE(mispredictE), .redirect_pcE(redirect_pcE),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    bpred_btb #(.XLEN(XLEN), .ENTRIES(ENTRIES), .TAG_W(TAG_W), .CNT_W(2), .GHR_W(GHR_W)) dutSmall (
        .clk(clk), .rst(rst), .pcF(pcF),
        .pred_hitF(smallHitF), .pred_takenF(smallTakenF), .pred_targetF(smallTargetF),
        .upd_validE(upd_validE), .upd_pcE(upd_pcE), .upd_pc_plus_4E(upd_pc_plus_4E),
        .upd_branchE(upd_branchE), .upd_jumpE(upd_jumpE), .upd_takenE(upd_takenE),
        .upd_targetE(upd_targetE), .pred_takenE(pred_takenE), .pred_targetE(pred_targetE),
        .mispredictE(smallMispredE), .redirect_pcE(smallRedirectE),
        .branch_cnt(smallBranchCnt), .mispred_cnt(smallMispredCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one record per BTB slot, counters as plain integers 0..3.
    bit          mValid  [ENTRIES];
    int unsigned mTag    [ENTRIES];
    bit          mJump   [ENTRIES];
    logic [31:0] mTarget [ENTRIES];
    int          mCtr    [ENTRIES];
    int unsigned mGhr;
    int unsigned mBr, mMis, mBrSmall, mMisSmall;

    int nVec = 0;
    int nErr = 0;

    function automatic int unsigned idxOf(input logic [31:0] pc);
        return (pc >> 2) % ENTRIES;
    endfunction

    function automatic int unsigned tagOf(input logic [31:0] pc);
        return (pc >> (IDX_W + 2)) % (1 << TAG_W);
    endfunction

    function automatic int unsigned ctrIdxOf(input logic [31:0] pc);
`ifdef BPRED_GSHARE_EN
        return idxOf(pc) ^ mGhr;
`else
        return idxOf(pc);
`endif
    endfunction

    function automatic void modelClear();
        for (int i = 0; i < ENTRIES; i++) begin
            mValid[i] = 0; mTag[i] = 0; mJump[i] = 0; mTarget[i] = '0; mCtr[i] = 1;
        end
        mGhr = 0; mBr = 0; mMis = 0; mBrSmall = 0; mMisSmall = 0;
    endfunction

    function automatic void modelPredict(input logic [31:0] pc, output bit hit, output bit tk,
                                         output logic [31:0] tgt);
        int unsigned i;
        i   = idxOf(pc);
        hit = mValid[i] && (mTag[i] == tagOf(pc));
        tk  = hit && (mJump[i] || mCtr[ctrIdxOf(pc)] >= 2);
        tgt = hit ? mTarget[i] : 32'h0;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input logic [31:0] pcf, input bit v, input logic [31:0] pc,
                        input bit br, input bit jp, input bit tk, input logic [31:0] tgt,
                        input bit ptk, input logic [31:0] ptgt, input bit chk);
        bit          eHit, eTk, res, eMis, hit;
        logic [31:0] eTgt, eRedir;
        int unsigned i, c;
        @(negedge clk);
        rst = r; pcF = pcf; upd_validE = v; upd_pcE = pc; upd_pc_plus_4E = pc + 32'd4;
        upd_branchE = br; upd_jumpE = jp; upd_takenE = tk; upd_targetE = tgt;
        pred_takenE = ptk; pred_targetE = ptgt;
        #1;
        modelPredict(pcf, eHit, eTk, eTgt);
        res    = v && (br || jp);
        eMis   = res && ((tk != ptk) || (tk && tgt != ptgt));
        eRedir = (res && tk) ? tgt : pc + 32'd4;
        if (chk) begin
            check("pred_hitF", 64'(pred_hitF), 64'(eHit));
            check("pred_takenF", 64'(pred_takenF), 64'(eTk));
            check("pred_targetF", 64'(pred_targetF), 64'(eTgt));
            check("mispredictE", 64'(mispredictE), 64'(eMis));
            check("redirect_pcE", 64'(redirect_pcE), 64'(eRedir));
            check("branch_cnt", 64'(branch_cnt), 64'(mBr));
            check("mispred_cnt", 64'(mispred_cnt), 64'(mMis));
            check("small_branch_cnt", 64'(smallBranchCnt), 64'(mBrSmall));
            check("small_mispred_cnt", 64'(smallMispredCnt), 64'(mMisSmall));
        end
        @(posedge clk);
        if (r) begin
            modelClear();
        end else if (res) begin
            i   = idxOf(pc);
            c   = ctrIdxOf(pc);
            hit = mValid[i] && (mTag[i] == tagOf(pc));
            if (hit && jp) begin
                mTarget[i] = tgt; mJump[i] = 1; mCtr[c] = 3;
            end else if (hit) begin
                mCtr[c] = tk ? ((mCtr[c] < 3) ? mCtr[c] + 1 : 3) : ((mCtr[c] > 0) ? mCtr[c] - 1 : 0);
                if (tk) mTarget[i] = tgt;
            end else if (tk) begin
                mValid[i] = 1; mTag[i] = tagOf(pc); mTarget[i] = tgt; mJump[i] = jp;
                mCtr[c] = jp ? 3 : 2;
            end
            if (mBr < 65535) mBr++;
            if (mBrSmall < 3) mBrSmall++;
            if (eMis && mMis < 65535) mMis++;
            if (eMis && mMisSmall < 3) mMisSmall++;
            if (br) mGhr = ((mGhr << 1) | 32'(tk)) % (1 << GHR_W);
        end
    endtask

    function automatic logic [31:0] randPc();
        if ($urandom_range(0, 7) == 0) return $urandom & 32'hFFFF_FFFC;
        return 32'($urandom_range(0, 1023)) << 2;
    endfunction

    initial begin
        bit          r, v, br, jp, tk, ptk, h;
        logic [31:0] pcf, pc, tgt, ptgt;
        int          kind;
        modelClear();
        rst = 1'b1; pcF = '0; upd_validE = 0; upd_pcE = '0; upd_pc_plus_4E = 32'd4;
        upd_branchE = 0; upd_jumpE = 0; upd_takenE = 0; upd_targetE = '0;
        pred_takenE = 0; pred_targetE = '0;

        // Reset, then reset again with a concurrent update that must be discarded.
        step(1, 32'h100, 0, 32'h0,   0, 0, 0, 32'h0,   0, 32'h0,   0);
        step(1, 32'h100, 1, 32'h100, 1, 0, 1, 32'h80,  0, 32'h0,   1);
        // Taken branch 0x100 -> 0x80, lookup in same cycle sees no bypass.
        step(0, 32'h100, 1, 32'h100, 1, 0, 1, 32'h80,  0, 32'h0,   1);
        // Not-taken three times: 10 -> 01 -> 00 -> 00.
        step(0, 32'h100, 1, 32'h100, 1, 0, 0, 32'h80,  1, 32'h80,  1);
        step(0, 32'h100, 1, 32'h100, 1, 0, 0, 32'h80,  0, 32'h0,   1);
        step(0, 32'h100, 1, 32'h100, 1, 0, 0, 32'h80,  0, 32'h0,   1);
        step(0, 32'h100, 0, 32'h0,   0, 0, 0, 32'h0,   0, 32'h0,   1);
        // Alias: 0x200 shares index 0 with 0x100 and evicts it.
        step(0, 32'h200, 1, 32'h200, 1, 0, 1, 32'h300, 0, 32'h0,   1);
        step(0, 32'h100, 0, 32'h0,   0, 0, 0, 32'h0,   0, 32'h0,   1);
        step(0, 32'h200, 0, 32'h0,   0, 0, 0, 32'h0,   0, 32'h0,   1);
        // jal 0x40 -> 0x400, then jalr 0x40 -> 0x500 against the stale prediction.
        step(0, 32'h40,  1, 32'h40,  0, 1, 1, 32'h400, 0, 32'h0,   1);
        step(0, 32'h40,  1, 32'h40,  0, 1, 1, 32'h500, 1, 32'h400, 1);
        step(0, 32'h40,  0, 32'h0,   0, 0, 0, 32'h0,   0, 32'h0,   1);
        // Extra mispredicts drive the 2-bit statistics counter into saturation.
        for (int k = 0; k < 4; k++) begin
            step(0, 32'h40, 1, 32'h80 + 32'(k * 4), 1, 0, 1, 32'h900, 0, 32'h0, 1);
        end
        // Mid-stream reset clears all training.
        step(1, 32'h40,  0, 32'h0,   0, 0, 0, 32'h0,   0, 32'h0,   1);
        step(0, 32'h40,  0, 32'h0,   0, 0, 0, 32'h0,   0, 32'h0,   1);

        for (int n = 0; n < 600; n++) begin
            r    = ($urandom_range(0, 79) == 0);
            pcf  = randPc();
            pc   = randPc();
            v    = ($urandom_range(0, 7) != 0);
            kind = $urandom_range(0, 3);
            br   = (kind == 1 || kind == 2);
            jp   = (kind == 3);
            tk   = jp ? 1'b1 : 1'($urandom_range(0, 1));
            tgt  = ($urandom_range(0, 1) == 1) ? randPc() : pc + 32'h40;
            if ($urandom_range(0, 1) == 1) begin
                modelPredict(pc, h, ptk, ptgt);
            end else begin
                ptk  = 1'($urandom_range(0, 1));
                ptgt = randPc();
            end
            step(r, pcf, v, pc, br, jp, tk, tgt, ptk, ptgt, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule

// File: doc/bpred_btb.md
Name: bpred_btb

Overview:
- Parametrised branch predictor for the 5-stage pipeline. Replaces the static "predict not-taken, resolve in Execute" PC-select scheme.
- Fetch stage: direct-mapped branch target buffer (BTB) plus 2-bit saturating counters give a predicted next PC in the same cycle.
- Execute stage: resolved branch/jump outcomes train the tables. The block flags a mispredict and supplies the redirect PC used for flushD/flushE.
- Sits beside pc/instruction_mem (Fetch) and the ALU/target adder (Execute).

Parameters:
- XLEN, 32, PC/target width in bits.
- ENTRIES, 64, BTB/counter entries; power of 2, minimum 4; IDX_W = log2(ENTRIES).
- TAG_W, 8, stored tag bits taken from PC above the index.
- CNT_W, 16, width of each statistics counter.
- GHR_W, 6, global history length; used only with the optional feature; must be ≤ IDX_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- pcF  in  XLEN  Fetch-stage PC.
- pred_hitF  out  1  valid BTB entry with matching tag.
- pred_takenF  out  1  predict redirect.
- pred_targetF  out  XLEN  predicted target; 0 when pred_hitF=0.
- upd_validE  in  1  Execute holds a valid (not flushed) instruction.
- upd_pcE  in  XLEN  PC of that instruction.
- upd_pc_plus_4E  in  XLEN  fall-through PC.
- upd_branchE  in  1  conditional branch.
- upd_jumpE  in  1  unconditional jump (jal/jalr).
- upd_takenE  in  1  actual outcome: branchE&zeroE, or 1 for a jump.
- upd_targetE  in  XLEN  actual target (pc_targetE).
- pred_takenE  in  1  pred_takenF piped down to Execute.
- pred_targetE  in  XLEN  pred_targetF piped down to Execute.
- mispredictE  out  1  redirect required.
- redirect_pcE  out  XLEN  correct next PC.
- branch_cnt  out  CNT_W  resolved branch+jump count.
- mispred_cnt  out  CNT_W  mispredict count.

Behaviour:
- Index and tag:
  - idx = pc[IDX_W+1:2].
  - tag = pc[IDX_W+TAG_W+1:IDX_W+2].
  - If IDX_W+TAG_W+2 > XLEN, the upper tag bits are zero-padded.
- Entry contents: valid, tag[TAG_W], is_jump, target[XLEN], ctr[2].
- Lookup is combinational from registered arrays, with zero-cycle latency:
  - pred_hitF = valid && tag match.
  - pred_takenF = pred_hitF && (is_jump || ctr[1]).
- Resolution (combinational) applies when res = upd_validE && (upd_branchE || upd_jumpE):
  - mispredictE = res && ((upd_takenE != pred_takenE) || (upd_takenE && upd_targetE != pred_targetE)).
  - redirect_pcE = upd_takenE ? upd_targetE : upd_pc_plus_4E.
  - When res=0, mispredictE=0 and redirect_pcE=upd_pc_plus_4E.
- Update, registered on the clk edge when res=1. Let e = entry at idx(upd_pcE) and hitE = e.valid && tag match.
  - hitE, branch: ctr saturating inc if taken, dec if not (00↔11 bounded). If taken, target←upd_targetE.
  - hitE, jump: target←upd_targetE, is_jump←1, ctr←11.
  - miss, taken: allocate and overwrite (no replacement policy). valid←1, tag, target, is_jump←upd_jumpE, ctr←10 for a branch or 11 for a jump.
  - miss, not taken: no write.
- Simultaneous lookup and update at the same index: the lookup sees the pre-update contents. No bypass.
- Statistics:
  - branch_cnt += 1 per res cycle.
  - mispred_cnt += 1 per mispredictE cycle.
  - Both saturate at all-ones and never wrap.
- Reset (synchronous, rst=1 at a clk edge):
  - All valid←0, ctr←01, is_jump←0, targets/tags←0.
  - Counters←0; GHR←0 when present.
  - Outputs follow: pred_hitF=0, pred_takenF=0, pred_targetF=0.
  - Reset dominates any concurrent update; an update in the reset cycle is discarded.
- rst is sampled only at the edge. Asserting it mid-stream loses all training, with no partial state.

Optional Feature:
- Macro: BPRED_GSHARE_EN.
- Defined:
  - A GHR_W-bit global history register shifts in upd_takenE on each upd_branchE resolution (jumps excluded).
  - The counter index becomes idx XOR {zero-extend GHR}. The BTB tag/target index stays idx.
  - GHR is updated in the same edge as the counters.
- Undefined: no GHR; counters are indexed by idx only (bimodal).

Test Plan:
- Reset, then pcF=0x100 → pred_hitF=0, pred_takenF=0, pred_targetF=0, counters 0.
- Taken branch pc=0x100→0x80 resolved once (pred_takenE=0) → mispredictE=1, redirect_pcE=0x80. Next lookup pcF=0x100 → hit, taken, target 0x80 (ctr=10).
- Same branch then resolved not-taken twice → ctr 10→01→00. pred_takenF=0 after the first; a third not-taken keeps ctr=00 (saturation). Second resolution gives mispredictE=0, redirect 0x104.
- Alias test, ENTRIES=64: pc 0x100 and 0x200 share idx 0 with different tags. Training 0x200 evicts 0x100 → lookup 0x100 gives pred_hitF=0.
- jal at 0x40→0x400, then jalr at 0x40→0x500 (pred_targetE=0x400) → mispredictE=1, redirect 0x500, entry target updated to 0x500; mispred_cnt=2, branch_cnt=2.
- Drive update and rst=1 in the same cycle → tables cleared, update discarded. Run with CNT_W=2 for 5 mispredicts → mispred_cnt holds 3.
